// File: rtl/axi4s_fifo_pkg.sv
// Shared types and FIFO word layout helpers for the AXI4-Stream to FIFO write bridge.
// The FIFO word is {tlast, tkeep, tdata} with tdata in the least significant bits.
package axi4s_fifo_pkg;

  typedef enum logic {
    S_PASS = 1'b0,
    S_DROP = 1'b1
  } state_t;

  function automatic int keep_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int word_w(input int data_w);
    return data_w + keep_w(data_w) + 1;
  endfunction

  function automatic int keep_ofs(input int data_w);
    return data_w;
  endfunction

  function automatic int last_ofs(input int data_w);
    return data_w + keep_w(data_w);
  endfunction

  // Layout for the default 32-bit stream; wider instances use the helpers above.
  localparam int DATA_W   = 32;
  localparam int KEEP_W   = keep_w(DATA_W);
  localparam int WORD_W   = DATA_W + KEEP_W + 1;
  localparam int DATA_OFS = 0;
  localparam int KEEP_OFS = keep_ofs(DATA_W);
  localparam int LAST_OFS = last_ofs(DATA_W);

endpackage

// File: rtl/axi4s_skid.sv
// Two-entry register slice: an output register plus one skid register.
// in_ready is registered and is simply "skid register empty".
module axi4s_skid #(
  parameter int DLEN = 8
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DLEN-1:0] out_data
);

  logic            out_valid_reg, out_valid_next;
  logic            skid_valid_reg, skid_valid_next;
  logic            ready_reg;
  logic [DLEN-1:0] out_data_reg, out_data_next;
  logic [DLEN-1:0] skid_data_reg, skid_data_next;
  logic            accept;
  logic            drain;

  assign accept = in_valid & ready_reg;
  assign drain  = out_valid_reg & out_ready;

  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (!out_valid_reg || drain) begin
      // ready_reg is low whenever the skid holds a beat, so accept and
      // a full skid never coincide here.
      if (skid_valid_reg) begin
        out_valid_next  = 1'b1;
        out_data_next   = skid_data_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_valid_next = 1'b1;
        out_data_next  = in_data;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
      out_data_reg   <= '0;
      skid_data_reg  <= '0;
    end else begin
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ~skid_valid_next;
      out_data_reg   <= out_data_next;
      skid_data_reg  <= skid_data_next;
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: rtl/axi4s_fifo_wr_pkt.sv
// AXI4-Stream slave feeding a synchronous FIFO write port through a skid stage,
// with optional packet-length policing (truncate at MAX_BEATS, drop the rest).
module axi4s_fifo_wr_pkt
  import axi4s_fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int PKT_MODE  = 0,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic [KEEP_W-1:0]        s_tkeep,
  input  logic                     s_tlast,
  output logic                     o_wen,
  output logic [DATA_W+KEEP_W:0]   o_wdata,
  input  logic                     i_wfull,
  output logic [CNT_W-1:0]         o_pkt_cnt,
  output logic [CNT_W-1:0]         o_drop_cnt,
  output logic                     o_ovf
);

  localparam int WORD_LEN = word_w(DATA_W);
  localparam int LAST_BIT = last_ofs(DATA_W);
  localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

  logic                is_null;
  logic [WORD_LEN-1:0] in_word;
  logic [WORD_LEN-1:0] out_word;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                wen;
  logic                force_last;

  state_t           state_reg, state_next;
  logic [15:0]      beat_cnt_reg, beat_cnt_next;
  logic [CNT_W-1:0] pkt_cnt_reg, pkt_cnt_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  // Null beats complete the handshake upstream but never enter the slice.
  assign is_null = (s_tkeep == '0) & ~s_tlast;
  assign in_word = {s_tlast, s_tkeep, s_tdata};

  axi4s_skid #(
    .DLEN (WORD_LEN)
  ) u_skid (
    .clk       (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_tvalid & ~is_null),
    .in_ready  (s_tready),
    .in_data   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_word)
  );

  assign out_last  = out_word[LAST_BIT];
  assign out_ready = ~i_wfull | (state_reg == S_DROP);
  assign wen       = out_valid & ~i_wfull & (state_reg != S_DROP);

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    pkt_cnt_next  = pkt_cnt_reg;
    drop_cnt_next = drop_cnt_reg;
    force_last    = 1'b0;
    if (PKT_MODE == 0) begin
      if (wen && out_last) begin
        pkt_cnt_next = pkt_cnt_reg + CNT_W'(1);
      end
    end else begin
      case (state_reg)
        S_PASS: begin
          if (wen) begin
            if (out_last) begin
              pkt_cnt_next  = pkt_cnt_reg + CNT_W'(1);
              beat_cnt_next = '0;
            end else if (beat_cnt_reg == LAST_BEAT) begin
              // Truncate: this write closes the packet, remainder is dropped.
              force_last    = 1'b1;
              pkt_cnt_next  = pkt_cnt_reg + CNT_W'(1);
              beat_cnt_next = '0;
              if (drop_cnt_reg != '1) begin
                drop_cnt_next = drop_cnt_reg + CNT_W'(1);
              end
              state_next = S_DROP;
            end else begin
              beat_cnt_next = beat_cnt_reg + 16'd1;
            end
          end
        end
        S_DROP: begin
          if (out_valid && out_last) begin
            state_next    = S_PASS;
            beat_cnt_next = '0;
          end
        end
        default: state_next = S_PASS;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg    <= S_PASS;
      beat_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      pkt_cnt_reg  <= pkt_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign o_wen      = wen;
  assign o_wdata    = {out_last | force_last, out_word[LAST_BIT-1:0]};
  assign o_ovf      = force_last;
  assign o_pkt_cnt  = pkt_cnt_reg;
  assign o_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_axi4s_fifo_wr_pkt.sv
// Directed bench: dut0 runs plain stream mode, dut1 runs packet mode with MAX_BEATS=4.
module tb_axi4s_fifo_wr_pkt;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast;
  logic        i_wfull;

  logic        s_tready0, s_tready1;
  logic        o_wen0, o_wen1;
  logic [36:0] o_wdata0, o_wdata1;
  logic [15:0] pkt0, pkt1, drop0, drop1;
  logic        o_ovf0, o_ovf1;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int sel = 0;
  logic clr = 1'b0;

  logic [36:0] wq0[$];
  logic [36:0] wq1[$];
  int          wc0[$];
  int          ovf_n0 = 0;
  int          ovf_n1 = 0;
  logic        rdy_low0 = 1'b0;

  axi4s_fifo_wr_pkt #(.DATA_W(32), .PKT_MODE(0), .MAX_BEATS(256), .CNT_W(16)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(s_tready0),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .o_wen(o_wen0),
    .o_wdata(o_wdata0), .i_wfull(i_wfull), .o_pkt_cnt(pkt0), .o_drop_cnt(drop0),
    .o_ovf(o_ovf0)
  );

  axi4s_fifo_wr_pkt #(.DATA_W(32), .PKT_MODE(1), .MAX_BEATS(4), .CNT_W(16)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(s_tready1),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .o_wen(o_wen1),
    .o_wdata(o_wdata1), .i_wfull(i_wfull), .o_pkt_cnt(pkt1), .o_drop_cnt(drop1),
    .o_ovf(o_ovf1)
  );

  always @(posedge aclk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle.
  always @(negedge aclk) begin
    if (o_wen0) begin
      wq0.push_back(o_wdata0);
      wc0.push_back(cyc);
    end
    if (o_wen1) wq1.push_back(o_wdata1);
    if (o_ovf0) ovf_n0++;
    if (o_ovf1) ovf_n1++;
    if (!s_tready0) rdy_low0 = 1'b1;
    if (clr) begin
      wq0.delete();
      wq1.delete();
      wc0.delete();
      ovf_n0 = 0;
      ovf_n1 = 0;
      rdy_low0 = 1'b0;
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, output int acc);
    logic rdy;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      rdy = (sel == 0) ? s_tready0 : s_tready1;
      if (rdy) acc = cyc;
      @(posedge aclk);
      #1;
      if (rdy) break;
    end
    s_tvalid = 1'b0;
    if (acc < 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: beat %h not accepted, got no ready, expected ready within 100 cycles", d);
    end
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    i_wfull  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    clr = 1'b1;
    @(posedge aclk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    i_wfull  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    tests_run++; if (s_tready0 !== 1'b0) begin tests_failed++; $display("FAIL rst_tready: got %b expected 0", s_tready0); end
    tests_run++; if (o_wen0 !== 1'b0) begin tests_failed++; $display("FAIL rst_wen: got %b expected 0", o_wen0); end
    tests_run++; if (o_wdata0 !== 37'd0) begin tests_failed++; $display("FAIL rst_wdata: got %h expected 0", o_wdata0); end
    tests_run++; if (pkt0 !== 16'd0) begin tests_failed++; $display("FAIL rst_pkt: got %0d expected 0", pkt0); end
    tests_run++; if (o_ovf1 !== 1'b0) begin tests_failed++; $display("FAIL rst_ovf: got %b expected 0", o_ovf1); end
    tests_run++; if (drop1 !== 16'd0) begin tests_failed++; $display("FAIL rst_drop: got %0d expected 0", drop1); end
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    tests_run++; if (s_tready0 !== 1'b1) begin tests_failed++; $display("FAIL rst_release_tready: got %b expected 1", s_tready0); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_back_to_back();
    int a, a0;
    logic [36:0] exp;
    sel = 0;
    do_reset();
    a0 = -1;
    for (int i = 0; i < 8; i++) begin
      send(32'(i), 4'hF, i == 7, a);
      if (i == 0) a0 = a;
    end
    repeat (4) @(posedge aclk);
    #1;
    tests_run++; if (wq0.size() !== 8) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 8", wq0.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < wq0.size()) begin
        exp = {i == 7, 4'hF, 32'(i)};
        tests_run++; if (wq0[i] !== exp) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, wq0[i], exp); end
        tests_run++; if (wc0[i] !== a0 + 1 + i) begin tests_failed++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, wc0[i], a0 + 1 + i); end
      end
    end
    tests_run++; if (pkt0 !== 16'd1) begin tests_failed++; $display("FAIL b2b_pkt: got %0d expected 1", pkt0); end
    tests_run++; if (rdy_low0 !== 1'b0) begin tests_failed++; $display("FAIL b2b_tready_low: got %b expected 0", rdy_low0); end
    $display("[TB] test_back_to_back: %0d writes", wq0.size());
  endtask

  task automatic test_backpressure();
    int a;
    logic [36:0] exp;
    sel = 0;
    do_reset();
    fork
      begin
        repeat (5) @(posedge aclk);
        #1 i_wfull = 1'b1;
        repeat (5) @(posedge aclk);
        #1 i_wfull = 1'b0;
      end
    join_none
    for (int i = 0; i < 20; i++) send(32'(i), 4'hF, i == 19, a);
    repeat (6) @(posedge aclk);
    #1;
    tests_run++; if (wq0.size() !== 20) begin tests_failed++; $display("FAIL bp_count: got %0d expected 20", wq0.size()); end
    for (int i = 0; i < 20; i++) begin
      if (i < wq0.size()) begin
        exp = {i == 19, 4'hF, 32'(i)};
        tests_run++; if (wq0[i] !== exp) begin tests_failed++; $display("FAIL bp_data[%0d]: got %h expected %h", i, wq0[i], exp); end
      end
    end
    tests_run++; if (rdy_low0 !== 1'b1) begin tests_failed++; $display("FAIL bp_tready_low: got %b expected 1", rdy_low0); end
    tests_run++; if (pkt0 !== 16'd1) begin tests_failed++; $display("FAIL bp_pkt: got %0d expected 1", pkt0); end
    $display("[TB] test_backpressure: %0d writes", wq0.size());
  endtask

  task automatic test_pkt_trunc();
    int a;
    logic [36:0] exp [6];
    sel = 1;
    do_reset();
    for (int i = 0; i < 7; i++) send(32'(i), 4'hF, i == 6, a);
    send(32'd10, 4'hF, 1'b0, a);
    send(32'd11, 4'hF, 1'b1, a);
    repeat (6) @(posedge aclk);
    #1;
    exp[0] = {1'b0, 4'hF, 32'd0};
    exp[1] = {1'b0, 4'hF, 32'd1};
    exp[2] = {1'b0, 4'hF, 32'd2};
    exp[3] = {1'b1, 4'hF, 32'd3};
    exp[4] = {1'b0, 4'hF, 32'd10};
    exp[5] = {1'b1, 4'hF, 32'd11};
    tests_run++; if (wq1.size() !== 6) begin tests_failed++; $display("FAIL trunc_count: got %0d expected 6", wq1.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < wq1.size()) begin
        tests_run++; if (wq1[i] !== exp[i]) begin tests_failed++; $display("FAIL trunc_data[%0d]: got %h expected %h", i, wq1[i], exp[i]); end
      end
    end
    tests_run++; if (ovf_n1 !== 1) begin tests_failed++; $display("FAIL trunc_ovf: got %0d pulses expected 1", ovf_n1); end
    tests_run++; if (drop1 !== 16'd1) begin tests_failed++; $display("FAIL trunc_drop: got %0d expected 1", drop1); end
    tests_run++; if (pkt1 !== 16'd2) begin tests_failed++; $display("FAIL trunc_pkt: got %0d expected 2", pkt1); end
    $display("[TB] test_pkt_trunc: %0d writes, %0d ovf", wq1.size(), ovf_n1);
  endtask

  task automatic test_pkt_exact();
    int a;
    logic [36:0] exp;
    sel = 1;
    do_reset();
    for (int i = 0; i < 4; i++) send(32'(i + 32), 4'hF, i == 3, a);
    repeat (4) @(posedge aclk);
    #1;
    tests_run++; if (wq1.size() !== 4) begin tests_failed++; $display("FAIL exact_count: got %0d expected 4", wq1.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wq1.size()) begin
        exp = {i == 3, 4'hF, 32'(i + 32)};
        tests_run++; if (wq1[i] !== exp) begin tests_failed++; $display("FAIL exact_data[%0d]: got %h expected %h", i, wq1[i], exp); end
      end
    end
    tests_run++; if (ovf_n1 !== 0) begin tests_failed++; $display("FAIL exact_ovf: got %0d pulses expected 0", ovf_n1); end
    tests_run++; if (drop1 !== 16'd0) begin tests_failed++; $display("FAIL exact_drop: got %0d expected 0", drop1); end
    tests_run++; if (pkt1 !== 16'd1) begin tests_failed++; $display("FAIL exact_pkt: got %0d expected 1", pkt1); end
    $display("[TB] test_pkt_exact: %0d writes", wq1.size());
  endtask

  task automatic test_null_beats();
    int a;
    logic [36:0] exp [3];
    sel = 0;
    do_reset();
    send(32'd1, 4'hF, 1'b0, a);
    send(32'd2, 4'h0, 1'b0, a);
    send(32'd3, 4'hF, 1'b0, a);
    send(32'd4, 4'h0, 1'b1, a);
    repeat (4) @(posedge aclk);
    #1;
    exp[0] = {1'b0, 4'hF, 32'd1};
    exp[1] = {1'b0, 4'hF, 32'd3};
    exp[2] = {1'b1, 4'h0, 32'd4};
    tests_run++; if (wq0.size() !== 3) begin tests_failed++; $display("FAIL null_count: got %0d expected 3", wq0.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < wq0.size()) begin
        tests_run++; if (wq0[i] !== exp[i]) begin tests_failed++; $display("FAIL null_data[%0d]: got %h expected %h", i, wq0[i], exp[i]); end
      end
    end
    tests_run++; if (pkt0 !== 16'd1) begin tests_failed++; $display("FAIL null_pkt: got %0d expected 1", pkt0); end
    tests_run++; if (ovf_n0 !== 0) begin tests_failed++; $display("FAIL mode0_ovf: got %0d pulses expected 0", ovf_n0); end
    tests_run++; if (drop0 !== 16'd0) begin tests_failed++; $display("FAIL mode0_drop: got %0d expected 0", drop0); end
    $display("[TB] test_null_beats: %0d writes", wq0.size());
  endtask

  task automatic test_reset_in_drop();
    int a;
    logic [36:0] exp;
    sel = 1;
    do_reset();
    for (int i = 0; i < 6; i++) send(32'(i + 64), 4'hF, 1'b0, a);
    repeat (4) @(posedge aclk);
    #1;
    tests_run++; if (wq1.size() !== 4) begin tests_failed++; $display("FAIL rdrop_pre_count: got %0d expected 4", wq1.size()); end
    tests_run++; if (drop1 !== 16'd1) begin tests_failed++; $display("FAIL rdrop_pre_drop: got %0d expected 1", drop1); end
    i_wfull = 1'b1;
    send(32'd70, 4'hF, 1'b0, a);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tests_run++; if (s_tready1 !== 1'b0) begin tests_failed++; $display("FAIL rdrop_tready: got %b expected 0", s_tready1); end
    tests_run++; if (o_wen1 !== 1'b0) begin tests_failed++; $display("FAIL rdrop_wen: got %b expected 0", o_wen1); end
    tests_run++; if (o_ovf1 !== 1'b0) begin tests_failed++; $display("FAIL rdrop_ovf: got %b expected 0", o_ovf1); end
    tests_run++; if (o_wdata1 !== 37'd0) begin tests_failed++; $display("FAIL rdrop_wdata: got %h expected 0", o_wdata1); end
    tests_run++; if (pkt1 !== 16'd0) begin tests_failed++; $display("FAIL rdrop_pkt: got %0d expected 0", pkt1); end
    tests_run++; if (drop1 !== 16'd0) begin tests_failed++; $display("FAIL rdrop_drop: got %0d expected 0", drop1); end
    i_wfull = 1'b0;
    clr = 1'b1;
    @(posedge aclk);
    #1;
    clr = 1'b0;
    send(32'd80, 4'hF, 1'b0, a);
    send(32'd81, 4'hF, 1'b1, a);
    repeat (4) @(posedge aclk);
    #1;
    tests_run++; if (wq1.size() !== 2) begin tests_failed++; $display("FAIL rdrop_post_count: got %0d expected 2", wq1.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < wq1.size()) begin
        exp = {i == 1, 4'hF, 32'(i + 80)};
        tests_run++; if (wq1[i] !== exp) begin tests_failed++; $display("FAIL rdrop_post_data[%0d]: got %h expected %h", i, wq1[i], exp); end
      end
    end
    tests_run++; if (pkt1 !== 16'd1) begin tests_failed++; $display("FAIL rdrop_post_pkt: got %0d expected 1", pkt1); end
    $display("[TB] test_reset_in_drop: %0d writes after reset", wq1.size());
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_pkt_trunc();
    test_pkt_exact();
    test_null_beats();
    test_reset_in_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
